inst_fetch: RTL and testbench

- Instruction fetch front end. Reads four bytes per instruction over the byte-wide memory port and packs them into a 32-bit word.
- Presents {if_pc, if_inst} with a valid/stall handshake to the if_id pipeline register.
- Packing order: byte at pc goes to if_inst[31:24]; if_id's byte swap then yields the little-endian instruction.
- Handles branch redirects, including abandoning a partially fetched word and draining an in-flight byte read.

---
 rtl/inst_fetch_pkg.sv | 27 ++
 rtl/inst_fetch.sv | 134 +++++++++++++
 tb/tb_inst_fetch.sv | 343 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/inst_fetch_pkg.sv
// rtl/inst_fetch_pkg.sv - shared constants, state encoding and helpers for inst_fetch
//
// Purpose: bus widths, reset polarity, zero word, the fetch FSM state
//          encoding and a word-alignment helper used by the fetch unit.
// Ports:   none (package).
package inst_fetch_pkg;

  localparam logic RST_ENABLE  = 1'b0;
  localparam int   INST_ADDR_W = 32;
  localparam int   INST_W      = 32;
  localparam int   BYTE_W      = 8;

  localparam logic [INST_W-1:0] ZERO_WORD = 32'h0000_0000;

  typedef enum logic [1:0] {
    IF_FETCH = 2'd0,
    IF_WAIT  = 2'd1,
    IF_HOLD  = 2'd2,
    IF_DRAIN = 2'd3
  } if_state_e;

  // Instructions are word aligned; the low two address bits are always dropped.
  function automatic logic [INST_ADDR_W-1:0] align_word(input logic [INST_ADDR_W-1:0] addr);
    return {addr[INST_ADDR_W-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/inst_fetch.sv
// rtl/inst_fetch.sv - byte-wide instruction fetch front end packing 4 bytes per word
//
// Purpose: issues one byte read at a time on a req/gnt/rvalid memory port,
//          packs the four bytes of an instruction big-end-first into if_inst
//          and presents {if_pc, if_inst} with if_valid until consumed
//          (stall_i low). Branch redirects abandon partial words and drain
//          any byte read still in flight.
// Ports:
//   clk             in   clock, all state updates on posedge
//   rst             in   synchronous reset, active low
//   stall_i         in   downstream cannot accept the presented word
//   branch_flag_i   in   redirect request
//   branch_target_i in   redirect address, bits [1:0] ignored
//   mem_req_o       out  byte read request
//   mem_addr_o      out  byte address of the request
//   mem_gnt_i       in   request accepted this cycle
//   mem_rvalid_i    in   read data valid
//   mem_rdata_i     in   read byte
//   if_pc           out  address of the presented instruction
//   if_inst         out  packed word {B[pc], B[pc+1], B[pc+2], B[pc+3]}
//   if_valid        out  if_pc/if_inst hold a complete word
module inst_fetch
  import inst_fetch_pkg::*;
#(
  parameter logic [INST_ADDR_W-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   stall_i,
  input  logic                   branch_flag_i,
  input  logic [INST_ADDR_W-1:0] branch_target_i,
  output logic                   mem_req_o,
  output logic [INST_ADDR_W-1:0] mem_addr_o,
  input  logic                   mem_gnt_i,
  input  logic                   mem_rvalid_i,
  input  logic [BYTE_W-1:0]      mem_rdata_i,
  output logic [INST_ADDR_W-1:0] if_pc,
  output logic [INST_W-1:0]      if_inst,
  output logic                   if_valid
);

  if_state_e              state_q, state_d;
  logic [INST_ADDR_W-1:0] pc_q, pc_d;
  logic [1:0]             cnt_q, cnt_d;
  logic [INST_ADDR_W-1:0] if_pc_d;
  logic [INST_W-1:0]      if_inst_d;
  logic                   if_valid_d;

  // The request is gated by rst so nothing is requested while reset is held;
  // the first request appears in the cycle right after reset is released.
  assign mem_req_o  = (rst != RST_ENABLE) && (state_q == IF_FETCH);
  assign mem_addr_o = mem_req_o ? (pc_q + {30'b0, cnt_q}) : ZERO_WORD;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    cnt_d      = cnt_q;
    if_pc_d    = if_pc;
    if_inst_d  = if_inst;
    if_valid_d = if_valid;

    case (state_q)
      IF_FETCH: begin
        if (mem_gnt_i) state_d = IF_WAIT;
      end
      IF_WAIT: begin
        if (mem_rvalid_i) begin
          case (cnt_q)
            2'd0: if_inst_d[31:24] = mem_rdata_i;
            2'd1: if_inst_d[23:16] = mem_rdata_i;
            2'd2: if_inst_d[15:8]  = mem_rdata_i;
            2'd3: if_inst_d[7:0]   = mem_rdata_i;
          endcase
          if (cnt_q == 2'd3) begin
            if_valid_d = 1'b1;
            if_pc_d    = pc_q;
            state_d    = IF_HOLD;
          end else begin
            cnt_d   = cnt_q + 2'd1;
            state_d = IF_FETCH;
          end
        end
      end
      IF_HOLD: begin
        if (!stall_i) begin
          pc_d       = pc_q + 32'd4;
          cnt_d      = 2'd0;
          if_valid_d = 1'b0;
          state_d    = IF_FETCH;
        end
      end
      IF_DRAIN: begin
        if (mem_rvalid_i) state_d = IF_FETCH;
      end
    endcase

    // A redirect overrides everything above except that the presented
    // pc/inst registers keep their old contents.
    if (branch_flag_i) begin
      pc_d       = align_word(branch_target_i);
      cnt_d      = 2'd0;
      if_valid_d = 1'b0;
      if_pc_d    = if_pc;
      if_inst_d  = if_inst;
      case (state_q)
        IF_FETCH: state_d = mem_gnt_i ? IF_DRAIN : IF_FETCH;
        IF_WAIT:  state_d = mem_rvalid_i ? IF_FETCH : IF_DRAIN;
        IF_HOLD:  state_d = IF_FETCH;
        // If the orphaned byte lands in the same cycle as a second redirect
        // the drain is complete; waiting on would never terminate.
        IF_DRAIN: state_d = mem_rvalid_i ? IF_FETCH : IF_DRAIN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      state_q  <= IF_FETCH;
      pc_q     <= align_word(RESET_PC);
      cnt_q    <= 2'd0;
      if_pc    <= ZERO_WORD;
      if_inst  <= ZERO_WORD;
      if_valid <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      cnt_q    <= cnt_d;
      if_pc    <= if_pc_d;
      if_inst  <= if_inst_d;
      if_valid <= if_valid_d;
    end
  end

endmodule

// File: tb/tb_inst_fetch.sv
// tb/tb_inst_fetch.sv - directed self-checking bench for inst_fetch
module tb_inst_fetch;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        stall_i = 1'b1;
  logic        branch_flag_i = 1'b0;
  logic [31:0] branch_target_i = 32'h0;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic        mem_gnt_i = 1'b1;
  logic        mem_rvalid_i = 1'b0;
  logic [7:0]  mem_rdata_i = 8'h0;
  logic [31:0] if_pc;
  logic [31:0] if_inst;
  logic        if_valid;

  int checks = 0;
  int errors = 0;

  logic [7:0]  mem [0:1023];
  int          rv_delay = 1;
  bit          pend = 1'b0;
  logic [31:0] pend_addr = 32'h0;
  int          wait_cnt = 0;
  logic [31:0] hs_q [$];

  inst_fetch #(.RESET_PC(32'h0000_0000)) dut (
    .clk             (clk),
    .rst             (rst),
    .stall_i         (stall_i),
    .branch_flag_i   (branch_flag_i),
    .branch_target_i (branch_target_i),
    .mem_req_o       (mem_req_o),
    .mem_addr_o      (mem_addr_o),
    .mem_gnt_i       (mem_gnt_i),
    .mem_rvalid_i    (mem_rvalid_i),
    .mem_rdata_i     (mem_rdata_i),
    .if_pc           (if_pc),
    .if_inst         (if_inst),
    .if_valid        (if_valid)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] mem_byte(input logic [31:0] a);
    if (a < 32'd1024) return mem[a[9:0]];
    return a[7:0] ^ 8'h5a;
  endfunction

  function automatic logic [31:0] word_at(input logic [31:0] a);
    return {mem_byte(a), mem_byte(a + 32'd1), mem_byte(a + 32'd2), mem_byte(a + 32'd3)};
  endfunction

  // Memory responder: evaluates at negedge what the next posedge will see.
  always @(negedge clk) begin
    mem_rvalid_i = 1'b0;
    if (!rst) begin
      pend = 1'b0;
    end else begin
      if (pend) begin
        if (wait_cnt == 0) begin
          mem_rvalid_i = 1'b1;
          mem_rdata_i  = mem_byte(pend_addr);
          pend         = 1'b0;
        end else begin
          wait_cnt--;
        end
      end
      if (mem_req_o && mem_gnt_i) begin
        pend      = 1'b1;
        pend_addr = mem_addr_o;
        wait_cnt  = rv_delay - 1;
        hs_q.push_back(mem_addr_o);
      end
      if (mem_rvalid_i && (mem_req_o || if_valid)) begin
        errors++;
        $display("FAIL protocol: rvalid while req=%0b valid=%0b", mem_req_o, if_valid);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    for (int i = 1; i <= 100; i++) begin
      tick();
      if (if_valid) begin
        n = i;
        break;
      end
    end
    checks++;
    if (n == 0) begin
      errors++;
      $display("FAIL wait_valid: timeout got if_valid=%0b need 1", if_valid);
    end
  endtask

  task automatic wait_addr(input logic [31:0] a);
    bit found;
    found = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (mem_req_o && mem_addr_o == a) begin
        found = 1'b1;
        break;
      end
      tick();
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL wait_addr: timeout got addr=%h need %h", mem_addr_o, a);
    end
  endtask

  task automatic consume();
    stall_i = 1'b0;
    tick();
    stall_i = 1'b1;
  endtask

  task automatic check_word(input string name, input logic [31:0] pc, input logic [31:0] inst);
    checks++;
    if (if_pc !== pc) begin
      errors++;
      $display("FAIL %s_pc: got %h need %h", name, if_pc, pc);
    end
    checks++;
    if (if_inst !== inst) begin
      errors++;
      $display("FAIL %s_inst: got %h need %h", name, if_inst, inst);
    end
  endtask

  task automatic check_first_hs(input string name, input logic [31:0] a);
    checks++;
    if (hs_q.size() == 0 || hs_q[0] !== a) begin
      errors++;
      $display("FAIL %s_hs: got %h (n=%0d) need %h", name,
               (hs_q.size() == 0) ? 32'hx : hs_q[0], hs_q.size(), a);
    end
  endtask

  task automatic test_reset();
    int n;
    rst = 1'b0;
    tick();
    tick();
    checks++;
    if ({if_valid, mem_req_o} !== 2'b00 || if_pc !== 32'h0 || if_inst !== 32'h0 || mem_addr_o !== 32'h0) begin
      errors++;
      $display("FAIL reset_outputs: got v=%0b req=%0b pc=%h inst=%h addr=%h need all 0",
               if_valid, mem_req_o, if_pc, if_inst, mem_addr_o);
    end
    hs_q.delete();
    rst = 1'b1;
    wait_valid(n);
    checks++;
    if (n != 8) begin
      errors++;
      $display("FAIL reset_latency: got %0d need 8", n);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (hs_q.size() <= i || hs_q[i] !== 32'(i)) begin
        errors++;
        $display("FAIL reset_addr_seq%0d: got %h need %h", i,
                 (hs_q.size() <= i) ? 32'hx : hs_q[i], 32'(i));
      end
    end
    check_word("first", 32'h0, 32'h1305_0000);
  endtask

  task automatic test_stall();
    int n;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (if_valid !== 1'b1 || mem_req_o !== 1'b0 || if_pc !== 32'h0 || if_inst !== 32'h1305_0000) begin
        errors++;
        $display("FAIL stall_hold%0d: got v=%0b req=%0b pc=%h inst=%h need 1 0 0 13050000",
                 i, if_valid, mem_req_o, if_pc, if_inst);
      end
    end
    hs_q.delete();
    consume();
    wait_valid(n);
    checks++;
    if (n != 8) begin
      errors++;
      $display("FAIL back_to_back_latency: got %0d need 8", n);
    end
    check_first_hs("stall_next", 32'h4);
    check_word("second", 32'h4, word_at(32'h4));
  endtask

  task automatic test_gnt_backpressure();
    int n;
    consume();
    wait_addr(32'h9);
    mem_gnt_i = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if (mem_req_o !== 1'b1 || mem_addr_o !== 32'h9) begin
        errors++;
        $display("FAIL gnt_stable%0d: got req=%0b addr=%h need 1 00000009", i, mem_req_o, mem_addr_o);
      end
    end
    mem_gnt_i = 1'b1;
    wait_valid(n);
    check_word("backpressure", 32'h8, word_at(32'h8));
  endtask

  task automatic test_branch_wait();
    int n;
    consume();
    rv_delay = 3;
    wait_addr(32'hE);
    tick();
    branch_flag_i   = 1'b1;
    branch_target_i = 32'h100;
    tick();
    branch_flag_i = 1'b0;
    rv_delay      = 1;
    checks++;
    if (if_valid !== 1'b0 || mem_req_o !== 1'b0) begin
      errors++;
      $display("FAIL drain_enter: got v=%0b req=%0b need 0 0", if_valid, mem_req_o);
    end
    tick();
    checks++;
    if (mem_req_o !== 1'b0) begin
      errors++;
      $display("FAIL drain_wait: got req=%0b need 0", mem_req_o);
    end
    hs_q.delete();
    wait_valid(n);
    check_first_hs("drain_next", 32'h100);
    check_word("after_drain", 32'h100, word_at(32'h100));
  endtask

  task automatic test_branch_rvalid();
    int n;
    consume();
    wait_addr(32'h107);
    tick();
    hs_q.delete();
    branch_flag_i   = 1'b1;
    branch_target_i = 32'h203;
    tick();
    branch_flag_i = 1'b0;
    checks++;
    if (if_valid !== 1'b0 || mem_req_o !== 1'b1 || mem_addr_o !== 32'h200) begin
      errors++;
      $display("FAIL branch_rvalid: got v=%0b req=%0b addr=%h need 0 1 00000200",
               if_valid, mem_req_o, mem_addr_o);
    end
    wait_valid(n);
    check_first_hs("branch_rvalid_next", 32'h200);
    check_word("branch_rvalid", 32'h200, word_at(32'h200));
  endtask

  task automatic test_wrap();
    int n;
    branch_flag_i   = 1'b1;
    branch_target_i = 32'hFFFF_FFFC;
    tick();
    branch_flag_i = 1'b0;
    checks++;
    if (if_valid !== 1'b0 || mem_req_o !== 1'b1 || mem_addr_o !== 32'hFFFF_FFFC) begin
      errors++;
      $display("FAIL branch_hold: got v=%0b req=%0b addr=%h need 0 1 fffffffc",
               if_valid, mem_req_o, mem_addr_o);
    end
    wait_valid(n);
    check_word("top_word", 32'hFFFF_FFFC, word_at(32'hFFFF_FFFC));
    mem_gnt_i = 1'b0;
    consume();
    checks++;
    if (mem_req_o !== 1'b1 || mem_addr_o !== 32'h0) begin
      errors++;
      $display("FAIL wrap_addr: got req=%0b addr=%h need 1 00000000", mem_req_o, mem_addr_o);
    end
    branch_flag_i   = 1'b1;
    branch_target_i = 32'h41;
    tick();
    branch_flag_i = 1'b0;
    checks++;
    if (mem_req_o !== 1'b1 || mem_addr_o !== 32'h40) begin
      errors++;
      $display("FAIL fetch_redirect: got req=%0b addr=%h need 1 00000040", mem_req_o, mem_addr_o);
    end
    mem_gnt_i = 1'b1;
  endtask

  task automatic test_mid_reset();
    int n;
    wait_addr(32'h42);
    tick();
    rst = 1'b0;
    tick();
    checks++;
    if ({if_valid, mem_req_o} !== 2'b00 || if_pc !== 32'h0 || if_inst !== 32'h0 || mem_addr_o !== 32'h0) begin
      errors++;
      $display("FAIL mid_reset: got v=%0b req=%0b pc=%h inst=%h addr=%h need all 0",
               if_valid, mem_req_o, if_pc, if_inst, mem_addr_o);
    end
    hs_q.delete();
    rst = 1'b1;
    wait_valid(n);
    checks++;
    if (n != 8) begin
      errors++;
      $display("FAIL mid_reset_latency: got %0d need 8", n);
    end
    check_first_hs("mid_reset_next", 32'h0);
    check_word("mid_reset", 32'h0, 32'h1305_0000);
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 8'(i * 7 + 3);
    mem[0] = 8'h13;
    mem[1] = 8'h05;
    mem[2] = 8'h00;
    mem[3] = 8'h00;
    test_reset();
    test_stall();
    test_gnt_backpressure();
    test_branch_wait();
    test_branch_rvalid();
    test_wrap();
    test_mid_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
